// File: rtl/hs_pkg.sv
// Shared types, pad indices and constants for the hs_stream_core pad-mapped streaming block.
package hs_pkg;
    localparam int IO_W   = 38;
    localparam int SAMP_W = 8;
    localparam int OUT_W  = 16;

    localparam int PIN_OUT_DATA_LSB = 8;
    localparam int PIN_OUT_LAST     = 24;
    localparam int PIN_OUT_VALID    = 25;
    localparam int PIN_OUT_READY    = 26;
    localparam int PIN_IN_READY     = 27;
    localparam int PIN_IN_VALID     = 28;
    localparam int PIN_IN_LAST      = 29;
    localparam int PIN_IN_DATA_LSB  = 30;

    // 1 = pad is an input (not driven); pins 8..25 and 27 are driven.
    localparam logic [IO_W-1:0] OEB_MASK = {10'h3FF, 1'b0, 1'b1, 18'h0, 8'hFF};

    localparam logic [OUT_W-1:0] E_SAT = 16'hFFFF;

    typedef enum logic {COLLECT, EMIT} state_t;
    typedef enum logic [1:0] {W_S, W_D, W_E} word_t;
endpackage

// File: rtl/hs_stream_if.sv
// Decoded stream bundle: 8-bit input stream in, 16-bit word stream out.
// Handshake: a beat moves on a clock edge where valid & ready are both 1; data/last hold while valid & !ready.
interface hs_stream_if;
    import hs_pkg::*;

    logic [SAMP_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/hs_stream_core_math.sv
// hs_group_math: combinational sum, difference and saturated energy of four signed 8-bit samples.
module hs_group_math
    import hs_pkg::*;
(
    input  logic [SAMP_W-1:0] x0,
    input  logic [SAMP_W-1:0] x1,
    input  logic [SAMP_W-1:0] x2,
    input  logic [SAMP_W-1:0] x3,
    output logic [OUT_W-1:0]  s,
    output logic [OUT_W-1:0]  d,
    output logic [OUT_W-1:0]  e
);
    logic signed [9:0]  v0, v1, v2, v3, p01, p23, sum, dif;
    logic signed [15:0] w0, w1, w2, w3, q0, q1, q2, q3;
    logic        [16:0] e_sum;

    assign v0  = {{2{x0[7]}}, x0};
    assign v1  = {{2{x1[7]}}, x1};
    assign v2  = {{2{x2[7]}}, x2};
    assign v3  = {{2{x3[7]}}, x3};
    assign p01 = v0 + v1;
    assign p23 = v2 + v3;
    assign sum = p01 + p23;
    assign dif = p01 - p23;
    assign s   = {{6{sum[9]}}, sum};
    assign d   = {{6{dif[9]}}, dif};

    // Each square is at most 16384, so a 16-bit signed product is exact.
    assign w0 = {{8{x0[7]}}, x0};
    assign w1 = {{8{x1[7]}}, x1};
    assign w2 = {{8{x2[7]}}, x2};
    assign w3 = {{8{x3[7]}}, x3};
    assign q0 = w0 * w0;
    assign q1 = w1 * w1;
    assign q2 = w2 * w2;
    assign q3 = w3 * w3;
    assign e_sum = {1'b0, q0} + {1'b0, q1} + {1'b0, q2} + {1'b0, q3};
    assign e = e_sum[16] ? E_SAT : e_sum[15:0];
endmodule

// File: rtl/hs_stream_core.sv
// Pad-mapped group streamer: 4 samples in, S/D/E words out. Define HS_INPUT_REG_EN to register io_in.
module hs_stream_core
    import hs_pkg::*;
(
    input  logic            clock,
    input  logic            resetb,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb
);
    logic [IO_W-1:0] pads;

`ifdef HS_INPUT_REG_EN
    always_ff @(posedge clock) begin
        if (!resetb) pads <= '0;
        else         pads <= io_in;
    end
`else
    assign pads = io_in;
`endif

    hs_stream_if st ();

    // Input data bus is bit-reversed on the pads: pin 30 carries the MSB.
    always_comb begin
        st.in_data = '0;
        for (int k = 0; k < SAMP_W; k++) st.in_data[SAMP_W-1-k] = pads[PIN_IN_DATA_LSB+k];
    end
    assign st.in_last   = pads[PIN_IN_LAST];
    assign st.in_valid  = pads[PIN_IN_VALID];
    assign st.out_ready = pads[PIN_OUT_READY];

    logic unused_pads;
    assign unused_pads = ^{pads[PIN_OUT_VALID:0], pads[PIN_IN_READY]};

    state_t                   state;
    word_t                    word;
    logic [1:0]               cnt;
    logic [3:0][SAMP_W-1:0]   x_q, x_nxt;
    logic                     last_q;
    logic [OUT_W-1:0]         d_q, e_q, out_data_q;
    logic                     out_last_q;
    logic [OUT_W-1:0]         s_w, d_w, e_w;

    always_comb begin
        x_nxt      = x_q;
        x_nxt[cnt] = st.in_data;
    end

    hs_group_math u_math (
        .x0 (x_nxt[0]),
        .x1 (x_nxt[1]),
        .x2 (x_nxt[2]),
        .x3 (x_nxt[3]),
        .s  (s_w),
        .d  (d_w),
        .e  (e_w)
    );

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state      <= COLLECT;
            word       <= W_S;
            cnt        <= '0;
            x_q        <= '0;
            last_q     <= 1'b0;
            d_q        <= '0;
            e_q        <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (st.in_valid) begin
                        x_q[cnt] <= st.in_data;
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3 || st.in_last) begin
                            state      <= EMIT;
                            word       <= W_S;
                            out_data_q <= s_w;
                            d_q        <= d_w;
                            e_q        <= e_w;
                            last_q     <= st.in_last;
                        end
                    end
                end
                EMIT: begin
                    if (st.out_ready) begin
                        case (word)
                            W_S: begin
                                out_data_q <= d_q;
                                word       <= W_D;
                            end
                            W_D: begin
                                out_data_q <= e_q;
                                out_last_q <= last_q;
                                word       <= W_E;
                            end
                            default: begin
                                state      <= COLLECT;
                                word       <= W_S;
                                cnt        <= '0;
                                x_q        <= '0;
                                last_q     <= 1'b0;
                                out_data_q <= '0;
                                out_last_q <= 1'b0;
                            end
                        endcase
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign st.in_ready  = (state == COLLECT);
    assign st.out_valid = (state == EMIT);
    assign st.out_data  = out_data_q;
    assign st.out_last  = out_last_q;

    always_comb begin
        io_out                                   = '0;
        io_out[PIN_IN_READY]                     = st.in_ready;
        io_out[PIN_OUT_VALID]                    = st.out_valid;
        io_out[PIN_OUT_LAST]                     = st.out_last;
        io_out[PIN_OUT_DATA_LSB +: OUT_W]        = st.out_data;
    end

    assign io_oeb = OEB_MASK;
endmodule

// File: tb/tb_hs_stream_core.sv
// Directed bench for hs_stream_core: vector table of sample groups plus stall and reset sequences.
module tb_hs_stream_core;
    import hs_pkg::*;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic [37:0] io_in, io_out, io_oeb;

    always #5 clock = ~clock;

    hs_stream_if bus ();

    hs_stream_core dut (
        .clock  (clock),
        .resetb (resetb),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    function automatic logic [37:0] pack_pins(input logic [7:0] d, input logic l, input logic v,
                                              input logic r);
        logic [37:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) p[30+k] = d[7-k];
        p[29] = l;
        p[28] = v;
        p[26] = r;
        return p;
    endfunction

    assign io_in         = pack_pins(bus.in_data, bus.in_last, bus.in_valid, bus.out_ready);
    assign bus.in_ready  = io_out[27];
    assign bus.out_valid = io_out[25];
    assign bus.out_last  = io_out[24];
    assign bus.out_data  = io_out[23:8];

    typedef struct {
        logic [3:0][7:0]  samp;
        int               n;
        logic             last;
        logic [2:0][15:0] exp;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic [7:0] a, b, c, d, input int n, input logic l,
                                input logic [15:0] s, df, e);
        vec_t v;
        v.samp = {d, c, b, a};
        v.n    = n;
        v.last = l;
        v.exp  = {e, df, s};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_sample(input logic [7:0] d, input logic l);
        int t;
        @(negedge clock);
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
    endtask

    // Drops the source; this negedge is the first one after the group's final transfer.
    task automatic end_burst();
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("s_latency_valid", 32'(bus.out_valid), 32'd1);
        check("in_ready_emit", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic recv_word(input string name, input logic exp_last);
        int          t;
        logic [15:0] e;
        @(negedge clock);
        bus.out_ready = 1'b1;
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check({name, "_timeout"}, 32'(bus.out_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        check(name, 32'(bus.out_data), 32'(e));
        check({name, "_last"}, 32'(bus.out_last), 32'(exp_last));
        @(posedge clock);
    endtask

    task automatic run_vec(input vec_t v);
        for (int j = 0; j < v.n; j++) send_sample(v.samp[j], v.last && (j == v.n - 1));
        end_burst();
        for (int w = 0; w < 3; w++) exp_q.push_back(v.exp[w]);
        recv_word("word_s", 1'b0);
        recv_word("word_d", 1'b0);
        recv_word("word_e", v.last);
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [37:0] oeb_exp;

        vecs[0] = mk(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b1, 16'h000A, 16'hFFFC, 16'h001E);
        vecs[1] = mk(8'h80, 8'h80, 8'h80, 8'h80, 4, 1'b0, 16'hFE00, 16'h0000, 16'hFFFF);
        vecs[2] = mk(8'h05, 8'h06, 8'h00, 8'h00, 2, 1'b1, 16'h000B, 16'h000B, 16'h003D);
        vecs[3] = mk(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4, 1'b0, 16'h01FC, 16'h0000, 16'hFC04);
        vecs[4] = mk(8'hFF, 8'hFE, 8'h03, 8'h80, 4, 1'b1, 16'hFF80, 16'h007A, 16'h400E);
        vecs[5] = mk(8'h10, 8'h00, 8'h00, 8'h00, 1, 1'b1, 16'h0010, 16'h0010, 16'h0100);

        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Clock/reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        oeb_exp = '1;
        for (int p = 8; p <= 25; p++) oeb_exp[p] = 1'b0;
        oeb_exp[27] = 1'b0;
        check("oeb_lo", 32'(io_oeb[31:0]), 32'(oeb_exp[31:0]));
        check("oeb_hi", 32'(io_oeb[37:32]), 32'(oeb_exp[37:32]));
        check("oeb_25", 32'(io_oeb[25]), 32'd0);
        check("oeb_37", 32'(io_oeb[37]), 32'd1);
        check("undriven_pins", 32'({io_out[37:28], io_out[26], io_out[7:0]}), 32'd0);
        resetb = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // out_ready held low for 5 cycles while D is presented
        send_sample(8'h01, 1'b0);
        send_sample(8'h02, 1'b0);
        send_sample(8'h03, 1'b0);
        send_sample(8'h04, 1'b1);
        end_burst();
        exp_q.push_back(16'h000A);
        exp_q.push_back(16'hFFFC);
        exp_q.push_back(16'h001E);
        recv_word("stall_s", 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            bus.out_ready = 1'b0;
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_d_hold", 32'(bus.out_data), 32'h0000FFFC);
            check("stall_last", 32'(bus.out_last), 32'd0);
        end
        recv_word("stall_d", 1'b0);
        recv_word("stall_e", 1'b1);
        @(negedge clock);
        bus.out_ready = 1'b0;

        // Reset mid-emit after S is accepted; partial group is discarded
        for (int j = 0; j < 4; j++) send_sample(8'h80, 1'b0);
        end_burst();
        exp_q.push_back(16'hFE00);
        recv_word("rst_mid_s", 1'b0);
        @(negedge clock);
        bus.out_ready = 1'b0;
        resetb = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_data", 32'(bus.out_data), 32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        resetb = 1'b1;
        exp_q.delete();
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
